sram_port_arbiter: RTL
======================

Name: sram_port_arbiter

Overview:
- Shares one single-ported unified SRAM between the instruction-fetch port and the MEM-stage data port of the 5-stage MIPS32 pipeline.
- Sequences each multi-cycle SRAM access with a programmable wait-state count and returns read data on a one-cycle ready pulse.
- Raises a stall request so the pipeline holds the requesting stage until its access completes.
- Sits between pc/if, the mem stage outputs (ce/we/sel/addr/data) and the SRAM pins.

Parameters:
- WAIT_CYCLES, 1, extra SRAM cycles per access beyond the first (0..15).
- MAX_DATA_RUN, 4, consecutive data grants allowed while fetch is waiting before fetch is forced through (1..15).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- inst_ce_i  in  1  fetch request; held until inst_ready_o.
- inst_addr_i  in  32  fetch byte address.
- inst_data_o  out  32  fetched word; valid while inst_ready_o=1, held afterwards.
- inst_ready_o  out  1  one-cycle fetch completion pulse.
- data_ce_i  in  1  data request from mem stage; held until data_ready_o.
- data_we_i  in  1  1 = write, 0 = read.
- data_sel_i  in  4  byte lane enables.
- data_addr_i  in  32  data byte address.
- data_wdata_i  in  32  store data (lanes pre-replicated by the mem stage).
- data_rdata_o  out  32  read word; valid while data_ready_o=1.
- data_ready_o  out  1  one-cycle data completion pulse (reads and writes).
- stallreq_o  out  1  pipeline stall request.
- sram_ce_o  out  1  SRAM chip enable.
- sram_we_o  out  1  SRAM write enable.
- sram_sel_o  out  4  SRAM byte enables.
- sram_addr_o  out  32  SRAM address.
- sram_wdata_o  out  32  SRAM write data.
- sram_rdata_i  in  32  SRAM read data, valid in the last ACCESS cycle.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, wait counter=0, run counter=0. All outputs are 0: ready pulses, rdata registers, all sram_* signals. stallreq_o follows its equation, so it is 0 when there are no requests. An in-flight access is aborted; a partial write is the software's problem.
- FSM states:
  - IDLE: arbitrate. If a request is granted, latch grant owner, we, sel, addr and wdata, load wait counter=WAIT_CYCLES, go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: drive sram_* from the latched values; sram_ce_o=1 and sram_we_o=latched we on every ACCESS cycle. When the counter is 0, capture sram_rdata_i into the owner's rdata register (reads only) and go to RESP. Otherwise decrement the counter.
  - RESP: pulse the owner's ready output for exactly one cycle, then always go to IDLE. RESP never arbitrates, so a request still held during RESP is not re-served.
- SRAM outputs in IDLE and RESP: ce=0, we=0, sel=0, addr=0, wdata=0.
- Fetch accesses drive sel=4'b1111 and we=0.
- Latency: request sampled in IDLE at cycle 0 → WAIT_CYCLES+1 ACCESS cycles → ready at cycle WAIT_CYCLES+2. WAIT_CYCLES=0 gives a single ACCESS cycle.
- Arbitration in IDLE:
  - Data wins over fetch, because it belongs to the older instruction.
  - Exception: when inst_ce_i=1 and run counter==MAX_DATA_RUN, fetch wins.
  - Run counter increments on a data grant while inst_ce_i=1, saturating at MAX_DATA_RUN. It clears on any fetch grant and on any data grant with inst_ce_i=0.
- stallreq_o = (inst_ce_i & ~inst_ready_o) | (data_ce_i & ~data_ready_o). Combinational, no registered delay.
- Requester drops ce during ACCESS: the access still completes, the ready pulse still fires (ignored), and the rdata register is still updated.
- Write completion: data_ready_o pulses; data_rdata_o keeps its previous value.
- Inputs are not re-sampled after the grant; changes on the request inputs during ACCESS have no effect.
- Alignment checks are not done here.

Decomposition:
- Shared defines file:
  - Reuse ChipEnable/ChipDisable, WRITEABLE/UNWRITEABLE, ZEROWORD, DataBus and DataAddrBus.
  - Add ARB_IDLE/ARB_ACCESS/ARB_RESP (2-bit) and ARB_OWNER_INST/ARB_OWNER_DATA.
- Sub-modules: none. The FSM, the wait counter and the run counter fit in one module of about 200 lines.

Test Plan:
1. WAIT_CYCLES=1, inst_ce_i=1, addr 0x0000_0040, SRAM returns 0x2401_0005 → sram_ce_o high in cycles 1-2; inst_ready_o=1 and inst_data_o=0x2401_0005 in cycle 3; stallreq_o=1 in cycles 0-2 and 0 in cycle 3.
2. Both ports request in the same cycle; data is a read of 0x100, SRAM data 0xDEAD_BEEF → data granted first, data_ready_o at cycle 3 with 0xDEAD_BEEF; fetch granted from IDLE at cycle 4, inst_ready_o at cycle 7.
3. Data store: we=1, sel=4'b0010, wdata=0x5A5A_5A5A, addr 0x203 → sram_we_o=1, sram_sel_o=4'b0010, sram_addr_o=0x203 for the full ACCESS window; data_ready_o pulses; data_rdata_o unchanged.
4. MAX_DATA_RUN=4, data_ce_i and inst_ce_i held high continuously → exactly four data grants, then one fetch grant, then the run counter restarts at 0.
5. rst driven low mid-ACCESS (asynchronously, between clock edges) → sram_ce_o, stallreq_o inputs aside, and all ready outputs go to 0 immediately; after release, the held request is re-served from IDLE with full latency.
6. WAIT_CYCLES=0, back-to-back fetches to 0x0 and 0x4 → each completes in 2 cycles after its IDLE grant, with one IDLE gap between them; no double service of the first request during RESP.

Source files
------------

// File: rtl/sram_port_arbiter_pkg.sv
// sram_port_arbiter_pkg: shared bus types, SRAM control constants and arbiter encodings
package sram_port_arbiter_pkg;
  localparam logic CHIP_ENABLE = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;
  localparam logic WRITEABLE = 1'b1;
  localparam logic UNWRITEABLE = 1'b0;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  typedef logic [31:0] data_bus_t;
  typedef logic [31:0] data_addr_bus_t;
  typedef enum logic [1:0] {ARB_IDLE = 2'd0, ARB_ACCESS = 2'd1, ARB_RESP = 2'd2} arb_state_t;
  typedef enum logic {ARB_OWNER_INST = 1'b0, ARB_OWNER_DATA = 1'b1} arb_owner_t;
endpackage

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-ported SRAM between instruction fetch and the MEM-stage data port,
// with programmable wait states and a bounded data-priority run so fetch cannot starve.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int MAX_DATA_RUN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_ce_i,
  input  logic [31:0] inst_addr_i,
  output logic [31:0] inst_data_o,
  output logic        inst_ready_o,
  input  logic        data_ce_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_sel_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_ready_o,
  output logic        stallreq_o,
  output logic        sram_ce_o,
  output logic        sram_we_o,
  output logic [3:0]  sram_sel_o,
  output logic [31:0] sram_addr_o,
  output logic [31:0] sram_wdata_o,
  input  logic [31:0] sram_rdata_i
);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
  localparam logic [3:0] RUN_MAX = 4'(MAX_DATA_RUN);
  arb_state_t state, state_nxt;
  arb_owner_t owner;
  logic [3:0] wait_cnt, run_cnt;
  logic acc_we;
  logic [3:0] acc_sel;
  data_addr_bus_t acc_addr;
  data_bus_t acc_wdata;
  logic fetch_win, grant, in_access;
  always_comb begin
    fetch_win = inst_ce_i & (~data_ce_i | (run_cnt == RUN_MAX));
    grant = (state == ARB_IDLE) & (inst_ce_i | data_ce_i);
    in_access = state == ARB_ACCESS;
    state_nxt = state == ARB_IDLE ? (grant ? ARB_ACCESS : ARB_IDLE) :
                state == ARB_ACCESS ? (wait_cnt == 4'd0 ? ARB_RESP : ARB_ACCESS) : ARB_IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ARB_IDLE;
    else state <= state_nxt;
  end
  // Run counter only grows while fetch is actually waiting behind a data grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner <= ARB_OWNER_INST;
      wait_cnt <= 4'd0;
      run_cnt <= 4'd0;
      acc_we <= UNWRITEABLE;
      acc_sel <= 4'd0;
      acc_addr <= ZERO_WORD;
      acc_wdata <= ZERO_WORD;
      inst_data_o <= ZERO_WORD;
      data_rdata_o <= ZERO_WORD;
    end else if (grant) begin
      owner <= fetch_win ? ARB_OWNER_INST : ARB_OWNER_DATA;
      acc_we <= fetch_win ? UNWRITEABLE : data_we_i;
      acc_sel <= fetch_win ? 4'hF : data_sel_i;
      acc_addr <= fetch_win ? inst_addr_i : data_addr_i;
      acc_wdata <= fetch_win ? ZERO_WORD : data_wdata_i;
      wait_cnt <= WAIT_LOAD;
      run_cnt <= (fetch_win | ~inst_ce_i) ? 4'd0 : (run_cnt == RUN_MAX ? run_cnt : run_cnt + 4'd1);
    end else if (in_access) begin
      if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
      else if (acc_we == UNWRITEABLE && owner == ARB_OWNER_INST) inst_data_o <= sram_rdata_i;
      else if (acc_we == UNWRITEABLE) data_rdata_o <= sram_rdata_i;
    end
  end
  always_comb begin
    inst_ready_o = (state == ARB_RESP) & (owner == ARB_OWNER_INST);
    data_ready_o = (state == ARB_RESP) & (owner == ARB_OWNER_DATA);
    stallreq_o = (inst_ce_i & ~inst_ready_o) | (data_ce_i & ~data_ready_o);
    sram_ce_o = in_access ? CHIP_ENABLE : CHIP_DISABLE;
    sram_we_o = in_access ? acc_we : UNWRITEABLE;
    sram_sel_o = in_access ? acc_sel : 4'd0;
    sram_addr_o = in_access ? acc_addr : ZERO_WORD;
    sram_wdata_o = in_access ? acc_wdata : ZERO_WORD;
  end
endmodule
